spike_event_collector: RTL and testbench

//  Upstream feeder for the memory-mapped IO device. Accepts address-event (AER) spikes on a

---
 rtl/spike_event_collector.sv | 94 +++++++++
 tb/tb_spike_event_collector.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/spike_event_collector.sv
// Collects AER spike events into a 128-bit timestep bitmap and publishes it on each tick.
// Latency: an event shows up at the first tick edge at or after its accept edge. No backpressure beyond enable.
module spike_event_collector #(
    parameter int TICK_DIV = 50000,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             sw_tick,
    input  logic             ev_valid,
    input  logic [6:0]       ev_addr,
    output logic             ev_ready,
    output logic [31:0]      spike_a,
    output logic [31:0]      spike_b,
    output logic [31:0]      spike_c,
    output logic [31:0]      spike_d,
    output logic [31:0]      timestep,
    output logic [CNT_W-1:0] ev_count,
    output logic             tick_out
);

    localparam int              DIV_W    = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [127:0]     work_q, work_d;
    logic [127:0]     pub_q, pub_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] evc_q, evc_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [31:0]      ts_q, ts_d;
    logic             tick_q, tick_d;

    logic             accept;
    logic             tick;
    logic [127:0]     ev_bit;
    logic [CNT_W-1:0] cnt_inc;

    always_comb begin
        accept          = ev_valid && enable;
        ev_bit          = '0;
        ev_bit[ev_addr] = accept;
        cnt_inc         = (accept && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
        tick            = (enable && (div_q == DIV_LAST)) || sw_tick;

        work_d = work_q | ev_bit;
        cnt_d  = cnt_inc;
        div_d  = enable ? div_q + DIV_W'(1) : div_q;
        pub_d  = pub_q;
        evc_d  = evc_q;
        ts_d   = ts_q;
        tick_d = tick;

        // A same-cycle event belongs to the timestep being closed.
        if (tick) begin
            pub_d  = work_q | ev_bit;
            evc_d  = cnt_inc;
            work_d = '0;
            cnt_d  = '0;
            div_d  = '0;
            ts_d   = ts_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            work_q <= '0;
            pub_q  <= '0;
            cnt_q  <= '0;
            evc_q  <= '0;
            div_q  <= '0;
            ts_q   <= '0;
            tick_q <= 1'b0;
        end else begin
            work_q <= work_d;
            pub_q  <= pub_d;
            cnt_q  <= cnt_d;
            evc_q  <= evc_d;
            div_q  <= div_d;
            ts_q   <= ts_d;
            tick_q <= tick_d;
        end
    end

    assign ev_ready = enable;
    assign spike_a  = pub_q[31:0];
    assign spike_b  = pub_q[63:32];
    assign spike_c  = pub_q[95:64];
    assign spike_d  = pub_q[127:96];
    assign timestep = ts_q;
    assign ev_count = evc_q;
    assign tick_out = tick_q;

endmodule

// File: tb/tb_spike_event_collector.sv
// Directed bench for spike_event_collector with TICK_DIV=24, CNT_W=4.
module tb_spike_event_collector;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        sw_tick;
    logic        ev_valid;
    logic [6:0]  ev_addr;
    logic        ev_ready;
    logic [31:0] spike_a, spike_b, spike_c, spike_d, timestep;
    logic [3:0]  ev_count;
    logic        tick_out;

    int n_vec = 0;
    int n_err = 0;
    int n;

    spike_event_collector #(.TICK_DIV(24), .CNT_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .sw_tick  (sw_tick),
        .ev_valid (ev_valid),
        .ev_addr  (ev_addr),
        .ev_ready (ev_ready),
        .spike_a  (spike_a),
        .spike_b  (spike_b),
        .spike_c  (spike_c),
        .spike_d  (spike_d),
        .timestep (timestep),
        .ev_count (ev_count),
        .tick_out (tick_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One cycle with an optional event and optional sw_tick.
    task automatic drive(input logic vld, input logic [6:0] addr, input logic swt);
        ev_valid = vld;
        ev_addr  = addr;
        sw_tick  = swt;
        cyc();
        ev_valid = 1'b0;
        sw_tick  = 1'b0;
    endtask

    task automatic wait_tick(output int cycles);
        cycles = 0;
        do begin
            cyc();
            cycles++;
        end while (!tick_out && cycles < 200);
    endtask

    task automatic chk_pub(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input logic [31:0] d,
                           input logic [31:0] cnt, input logic [31:0] ts);
        chk({tag, "_a"}, spike_a, a);
        chk({tag, "_b"}, spike_b, b);
        chk({tag, "_c"}, spike_c, c);
        chk({tag, "_d"}, spike_d, d);
        chk({tag, "_cnt"}, 32'(ev_count), cnt);
        chk({tag, "_ts"}, timestep, ts);
    endtask

    initial begin
        reset    = 1'b1;
        enable   = 1'b0;
        sw_tick  = 1'b0;
        ev_valid = 1'b0;
        ev_addr  = '0;
        #2;
        chk_pub("rst", 0, 0, 0, 0, 0, 0);
        chk("rst_tick", 32'(tick_out), 0);
        chk("rst_rdy", 32'(ev_ready), 0);
        cyc();
        cyc();
        reset = 1'b0;
        cyc();

        // Basic collection and publish via sw_tick
        enable = 1'b1;
        #1;
        chk("rdy_en", 32'(ev_ready), 1);
        drive(1'b1, 7'd0, 1'b0);
        drive(1'b1, 7'd31, 1'b0);
        drive(1'b1, 7'd32, 1'b0);
        drive(1'b1, 7'd127, 1'b0);
        chk("t1_pre_a", spike_a, 0);
        drive(1'b0, 7'd0, 1'b1);
        chk("t1_tick", 32'(tick_out), 1);
        chk_pub("t1", 32'h80000001, 32'h1, 0, 32'h80000000, 4, 1);
        cyc();
        chk("t1_pulse", 32'(tick_out), 0);
        chk("t1_hold_a", spike_a, 32'h80000001);

        // Natural ticks every 24 cycles with no events
        wait_tick(n);
        chk("t2_per0", 32'(n + 1), 24);
        chk_pub("t2_0", 0, 0, 0, 0, 0, 2);
        wait_tick(n);
        chk("t2_per1", 32'(n), 24);
        chk("t2_ts1", timestep, 3);
        wait_tick(n);
        chk("t2_per2", 32'(n), 24);
        chk("t2_ts2", timestep, 4);

        // Repeated address plus an event in the tick cycle, then back-to-back sw_tick
        drive(1'b1, 7'd5, 1'b0);
        drive(1'b1, 7'd5, 1'b0);
        drive(1'b1, 7'd5, 1'b0);
        drive(1'b1, 7'd64, 1'b1);
        chk_pub("t3", 32'h20, 0, 32'h1, 0, 4, 5);
        drive(1'b0, 7'd0, 1'b1);
        chk("t3b_tick", 32'(tick_out), 1);
        chk_pub("t3b", 0, 0, 0, 0, 0, 6);

        // Counter saturation with 20 events
        for (int i = 0; i < 20; i++)
            drive(1'b1, (i < 10) ? 7'(i) : 7'(96 + i), 1'b0);
        drive(1'b0, 7'd0, 1'b1);
        chk_pub("t4", 32'h000003FF, 0, 0, 32'h000FFC00, 32'hF, 7);

        // Enable drop freezes divider and blocks events
        drive(1'b1, 7'd40, 1'b0);
        drive(1'b1, 7'd40, 1'b0);
        drive(1'b1, 7'd40, 1'b0);
        enable = 1'b0;
        #1;
        chk("t5_rdy", 32'(ev_ready), 0);
        for (int i = 0; i < 5; i++)
            drive(1'b1, 7'd41, 1'b0);
        chk("t5_no_tick", 32'(tick_out), 0);
        enable = 1'b1;
        wait_tick(n);
        chk("t5_delay", 32'(n), 21);
        chk_pub("t5", 0, 32'h100, 0, 0, 3, 8);
        enable = 1'b0;
        drive(1'b0, 7'd0, 1'b1);
        chk("t5_swt", 32'(tick_out), 1);
        chk_pub("t5s", 0, 0, 0, 0, 0, 9);

        // Async reset mid-timestep discards partial bitmap
        enable = 1'b1;
        drive(1'b1, 7'd1, 1'b0);
        drive(1'b1, 7'd2, 1'b0);
        drive(1'b1, 7'd3, 1'b0);
        reset = 1'b1;
        #2;
        chk_pub("t6_rst", 0, 0, 0, 0, 0, 0);
        chk("t6_rst_tick", 32'(tick_out), 0);
        cyc();
        reset = 1'b0;
        drive(1'b1, 7'd7, 1'b0);
        drive(1'b0, 7'd0, 1'b1);
        chk_pub("t6", 32'h80, 0, 0, 0, 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
